// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong buffer that takes bit-reversed FFT frames and
// streams them back out in natural order.
module fft_reorder_buf #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_ip,
  input  logic [W-1:0] ip_re,
  input  logic [W-1:0] ip_im,
  output logic         start_op,
  output logic         op_valid,
  output logic [W-1:0] op_re,
  output logic [W-1:0] op_im,
  output logic [N-1:0] op_idx,
  output logic         frame_err
);
  localparam int L = 1 << N;
  localparam logic [N-1:0] LAST = N'(L - 1);
  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;
  function automatic logic [N-1:0] bitrev(input logic [N-1:0] k);
    for (int i = 0; i < N; i++) bitrev[i] = k[N-1-i];
  endfunction
  logic [2*W-1:0] mem [2][L];
  wstate_t ws_q, ws_d;
  logic [N-1:0] wcnt_q, wcnt_d;
  logic wbank_q, wbank_d;
  logic rd_req_q, rd_req_d, rd_bank_q, rd_bank_d;
  logic ferr_q, ferr_d;
  logic we;
  logic [N-1:0] waddr;
  rstate_t rs_q, rs_d;
  logic [N-1:0] rcnt_q, rcnt_d;
  logic rbank_q, rbank_d;
  logic valid_q, valid_d, sop_q, sop_d;
  logic [W-1:0] re_q, re_d, im_q, im_d;
  logic [N-1:0] idx_q, idx_d;
  logic rb;
  logic [N-1:0] ra;
  logic [2*W-1:0] rdata;
  always_comb begin
    ws_d = ws_q;
    wcnt_d = wcnt_q;
    wbank_d = wbank_q;
    rd_req_d = 1'b0;
    rd_bank_d = rd_bank_q;
    ferr_d = 1'b0;
    we = 1'b0;
    waddr = bitrev(wcnt_q);
    if (start_ip) begin
      we = 1'b1;
      waddr = '0;
      wcnt_d = N'(1);
      ws_d = W_FILL;
      ferr_d = ws_q == W_FILL;
    end else if (ws_q == W_FILL) begin
      we = 1'b1;
      wcnt_d = wcnt_q + N'(1);
      if (wcnt_q == LAST) begin
        ws_d = W_IDLE;
        wbank_d = ~wbank_q;
        rd_req_d = 1'b1;
        rd_bank_d = wbank_q;
      end
    end
  end
  // A fresh completion takes priority so back-to-back frames drain without a gap.
  assign rb = rd_req_q ? rd_bank_q : rbank_q;
  assign ra = rd_req_q ? '0 : rcnt_q;
  assign rdata = mem[rb][ra];
  always_comb begin
    rs_d = rs_q;
    rcnt_d = rcnt_q;
    rbank_d = rbank_q;
    valid_d = 1'b0;
    sop_d = 1'b0;
    re_d = re_q;
    im_d = im_q;
    idx_d = idx_q;
    if (rd_req_q || rs_q == R_DRAIN) begin
      valid_d = 1'b1;
      sop_d = ra == '0;
      idx_d = ra;
      {re_d, im_d} = rdata;
      rbank_d = rb;
      rcnt_d = ra + N'(1);
      rs_d = ra == LAST ? R_IDLE : R_DRAIN;
    end
  end
  always_ff @(posedge clk) if (we && !rst) mem[wbank_q][waddr] <= {ip_re, ip_im};
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_q <= W_IDLE;
      wcnt_q <= '0;
      wbank_q <= 1'b0;
      rd_req_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ferr_q <= 1'b0;
      rs_q <= R_IDLE;
      rcnt_q <= '0;
      rbank_q <= 1'b0;
      valid_q <= 1'b0;
      sop_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
      idx_q <= '0;
    end else begin
      ws_q <= ws_d;
      wcnt_q <= wcnt_d;
      wbank_q <= wbank_d;
      rd_req_q <= rd_req_d;
      rd_bank_q <= rd_bank_d;
      ferr_q <= ferr_d;
      rs_q <= rs_d;
      rcnt_q <= rcnt_d;
      rbank_q <= rbank_d;
      valid_q <= valid_d;
      sop_q <= sop_d;
      re_q <= re_d;
      im_q <= im_d;
      idx_q <= idx_d;
    end
  end
  assign start_op = sop_q;
  assign op_valid = valid_q;
  assign op_re = re_q;
  assign op_im = im_q;
  assign op_idx = idx_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: directed and random frames checked every cycle against
// a queue-based model of the reorder buffer.
module tb_fft_reorder_buf;
  localparam int N = 3;
  localparam int W = 16;
  localparam int L = 1 << N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_ip = 1'b0;
  logic [W-1:0] ip_re = '0;
  logic [W-1:0] ip_im = '0;
  logic start_op, op_valid, frame_err;
  logic [W-1:0] op_re, op_im;
  logic [N-1:0] op_idx;
  typedef struct packed {
    logic [N-1:0] idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } exp_t;
  exp_t sched[$];
  logic [2*W-1:0] frm[$];
  bit active = 0;
  bit e_val = 0;
  bit e_err = 0;
  logic [W-1:0] e_re = '0;
  logic [W-1:0] e_im = '0;
  logic [N-1:0] e_idx = '0;
  int compared = 0;
  int mismatched = 0;

  fft_reorder_buf #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
    .start_op(start_op), .op_valid(op_valid), .op_re(op_re), .op_im(op_im),
    .op_idx(op_idx), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int n);
    int r = 0;
    for (int b = 0; b < N; b++) r = r * 2 + ((n >> b) % 2);
    return r;
  endfunction

  // Drive one cycle, advance the model by one clock edge, then compare.
  task automatic step(input bit r, input bit s, input logic [W-1:0] re, input logic [W-1:0] im);
    bit done = 0;
    exp_t e;
    rst = r;
    start_ip = s;
    ip_re = re;
    ip_im = im;
    @(posedge clk);
    #1;
    e_err = 0;
    if (r) begin
      frm.delete();
      sched.delete();
      active = 0;
      e_re = '0;
      e_im = '0;
      e_idx = '0;
    end else if (s) begin
      e_err = active;
      frm.delete();
      frm.push_back({re, im});
      active = 1;
    end else if (active) begin
      frm.push_back({re, im});
      if (frm.size() == L) begin
        done = 1;
        active = 0;
      end
    end
    e_val = sched.size() != 0;
    if (e_val) begin
      e = sched.pop_front();
      e_idx = e.idx;
      e_re = e.re;
      e_im = e.im;
    end
    if (done)
      for (int n = 0; n < L; n++) begin
        e.idx = N'(n);
        {e.re, e.im} = frm[brev(n)];
        sched.push_back(e);
      end
    chk("op_valid", 32'(op_valid), 32'(e_val));
    chk("start_op", 32'(start_op), 32'(e_val && e_idx == '0));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("op_idx", 32'(op_idx), 32'(e_idx));
    chk("op_re", 32'(op_re), 32'(e_re));
    chk("op_im", 32'(op_im), 32'(e_im));
  endtask

  task automatic send(input int n, input int base, input bit rnd);
    for (int k = 0; k < n; k++)
      step(0, k == 0, rnd ? W'($urandom) : W'(base + k), rnd ? W'($urandom) : W'(-(base + k)));
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int k = 0; k < n; k++)
      step(0, 0, rnd ? W'($urandom) : '0, rnd ? W'($urandom) : '0);
  endtask

  initial begin
    step(1, 1, W'(5), W'(6));
    step(1, 0, '0, '0);
    idle(20, 1);
    send(8, 0, 0);
    idle(10, 0);
    send(8, 0, 0);
    send(8, 16, 0);
    send(8, 32, 0);
    idle(10, 1);
    send(4, 50, 0);
    send(8, 100, 0);
    idle(10, 0);
    send(8, 0, 1);
    idle(4, 0);
    chk("drain_idx_before_rst", 32'(op_idx), 32'd3);
    step(1, 0, '0, '0);
    idle(10, 1);
    send(8, 200, 0);
    idle(10, 0);
    send(7, 60, 0);
    send(8, 300, 0);
    idle(10, 0);
    repeat (3) send(8, 0, 1);
    send(8, 400, 0);
    idle(12, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Sink for the radix-2 SDF FFT output stream. Each frame arrives as 2^N complex samples in bit-reversed index order, one per cycle, marked by a start pulse.
- The block writes each frame into a ping-pong RAM at bit-reversed addresses. It reads the other bank back in natural order.
- It sits between the FFT core output and downstream consumers. Continuous back-to-back frames produce a gapless natural-order output stream.

Parameters:
- N, 3, log2 of FFT length; frame length L = 2^N.
- W, 16, width of each signed fixed-point component (re and im).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start_ip  input  1  pulse marking the first sample (index 0) of an incoming frame.
- ip_re  input  W  real part of the incoming sample, signed.
- ip_im  input  W  imaginary part of the incoming sample, signed.
- start_op  output  1  one-cycle pulse coincident with output index 0.
- op_valid  output  1  high while op_re/op_im carry frame data.
- op_re  output  W  real part, natural order.
- op_im  output  W  imaginary part, natural order.
- op_idx  output  N  natural-order index of the current output.
- frame_err  output  1  one-cycle pulse: the incoming frame was aborted by a premature start_ip.

Behaviour:
- Storage: 2 banks × L entries × 2W bits. Bank contents are not cleared by rst.
- Reset: on rst=1 at a clock edge:
  - start_op, op_valid, frame_err, op_re, op_im, op_idx all go to 0.
  - Write FSM goes to IDLE; read FSM goes to IDLE; wbank = 0.
  - rst overrides all other inputs that cycle, including start_ip.
- Write FSM, states IDLE and FILL, counter wcnt[N-1:0]:
  - IDLE: inputs are ignored. If start_ip=1, write ip to bank[wbank][bitrev(0)], set wcnt=1, go to FILL.
  - FILL, start_ip=0: write ip to bank[wbank][bitrev(wcnt)], then wcnt++.
  - FILL, wcnt = L-1 (frame complete): wcnt wraps to 0; toggle wbank; raise internal rd_req with the completed bank id; go to IDLE.
  - FILL, start_ip=1 (this includes the cycle that would be sample L-1): the partial frame is discarded. Pulse frame_err the next cycle. Write ip as index 0 of a new frame in the same bank; wcnt=1; stay in FILL.
  - A start_ip in the cycle directly after frame completion is legal. It starts the next frame in the toggled bank, so back-to-back frames have no gap.
  - bitrev(k): reverse the N bits of k, so bit i maps to bit N-1-i.
- Read FSM, states IDLE and DRAIN, counter rcnt[N-1:0]:
  - rd_req with read FSM in IDLE: go to DRAIN with rcnt=0, reading from rbank = completed bank.
  - DRAIN: read is registered. Each cycle, op_re/op_im = bank[rbank][rcnt], op_idx = rcnt, op_valid = 1. start_op = 1 when rcnt = 0.
  - DRAIN, rcnt = L-1: return to IDLE, except when a new rd_req arrives the same cycle. In that case continue seamlessly: rcnt = 0 on the new bank.
  - IDLE: op_valid = 0 and start_op = 0; op_re/op_im/op_idx hold their last values.
- Latency: the last input sample is written at edge t. Output index 0 appears after edge t+1, i.e. 2 cycles after the last input sample is presented.
- Overrun: not possible. A fill takes at least L cycles and a drain exactly L cycles, so bank rbank is never rewritten while it is being drained.
- Arithmetic: none. Data passes bit-exact, with no rounding or sign manipulation.

Test Plan:
- Single frame, N=3, W=16: start_ip with ip_re = 0,1,…,7 and ip_im = -ip_re in consecutive cycles. Required: op_re = 0,4,2,6,1,5,3,7; op_im = the negation of each; op_idx = 0..7; start_op only with idx 0; op_valid high for exactly 8 cycles, beginning 2 cycles after sample 7.
- Back-to-back: three frames with no gap, frame f carrying ip_re = 16f + k. Required: 24 consecutive op_valid cycles with no gap; start_op at outputs 0, 8 and 16; each frame is reordered correctly.
- Mid-frame restart: start_ip, 4 samples, then start_ip again followed by a full 8-sample frame of values 100..107. Required: frame_err pulses once; exactly one output frame, carrying 100,104,102,106,101,105,103,107.
- Idle gaps and ignored input: random data on ip without start_ip for 20 cycles, then one valid frame. Required: no op_valid during the idle cycles; the single frame is output correctly.
- Reset mid-drain: assert rst while op_idx = 3. Required: op_valid, start_op, frame_err and op_* = 0 the next cycle; no further output until a new full frame arrives, which then reorders correctly.
- Restart at the boundary: start_ip asserted on the cycle of sample 7. Required: frame_err pulses; no output for the aborted frame; the new frame proceeds normally.
